hazard_unit: RTL and testbench
==============================

# hazard_unit

Load-use hazard detection unit for the 5-stage pipelined processor. It sits between the ID and EX stages. When the instruction in EX is a load whose destination register (Rt) matches a source register of the instruction in ID, it freezes the PC and the IF/ID register for one cycle and tells the ID/EX control mux to inject a bubble. It also keeps a registered stall-cycle counter and a last-cycle-stalled flag for debug and performance monitoring.

## Interface
Parameters:
- REG_ADDR_W, default 5: register-specifier width.
- CNT_W, default 16: stall-counter width.

Ports:
- clk, input, 1: single clock; every register updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- IDRegRs, input, REG_ADDR_W: Rs field of the instruction in ID.
- IDRegRt, input, REG_ADDR_W: Rt field of the instruction in ID.
- EXRegRt, input, REG_ADDR_W: Rt (load destination) of the instruction in EX.
- EXMemRead, input, 1: the EX-stage instruction reads memory (load).
- PCWrite, output, 1: 1 lets the PC update; 0 holds it.
- IFIDWrite, output, 1: 1 lets the IF/ID register update; 0 holds it.
- HazMuxCon, output, 1: 1 selects zero control signals into ID/EX (bubble).
- Stalled, output, 1: registered; 1 if the previous cycle was a stall cycle.
- StallCount, output, CNT_W: registered saturating count of stall cycles since reset.

## Operation
- Hazard term, combinational: hazard = EXMemRead & ((EXRegRt == IDRegRs) | (EXRegRt == IDRegRt)).
- Register 0 gets no special treatment. A match on register 0 still stalls, which is conservative but correct.
- hazard = 1: PCWrite = 0, IFIDWrite = 0, HazMuxCon = 1.
- hazard = 0: PCWrite = 1, IFIDWrite = 1, HazMuxCon = 0.
- The three primary outputs are always mutually consistent: PCWrite == IFIDWrite == ~HazMuxCon.
- An X or Z on EXMemRead must not be masked. Outputs follow normal 4-state evaluation of the expression.
- Stalled register: loaded with hazard on every rising edge.
- StallCount register: increments by 1 on every rising edge where hazard = 1. It saturates at all-ones and never wraps.
- Both Rs and Rt matching at once is a single hazard, so one stall cycle is counted per stalled clock edge.
- A persistent hazard keeps the outputs stalled. Once the load advances (EXMemRead drops or EXRegRt changes), the outputs release in the same cycle. No extra cycle is inserted.

## Timing
- PCWrite, IFIDWrite and HazMuxCon are purely combinational from the four data inputs. They have zero-cycle latency and must settle within the same clock period, with no clock dependency.
- rst_n low, asynchronously: Stalled = 0 and StallCount = 0.
- rst_n low also forces the combinational outputs to PCWrite = 0, IFIDWrite = 0, HazMuxCon = 1, holding the pipeline during reset.
- Release of rst_n: the combinational outputs resume normal evaluation immediately. The registers begin updating at the first rising clk edge after release.
- Reset asserted mid-stall: the counter clears at once and the outputs go to the reset (hold) values.
- Stalled and StallCount reflect hazard one cycle later (one-cycle latency).

## Test plan
- Rs hazard: EXMemRead=1, EXRegRt=5, IDRegRs=5, IDRegRt=9 -> PCWrite=0, IFIDWrite=0, HazMuxCon=1. After the next edge, Stalled=1 and StallCount increments by 1.
- Rt hazard and double match: EXMemRead=1, EXRegRt=3, IDRegRt=3, IDRegRs=3 -> stall outputs; one edge adds exactly 1 to StallCount.
- No load: EXMemRead=0 with all addresses equal (for example all 7) -> PCWrite=1, IFIDWrite=1, HazMuxCon=0, and the counter is unchanged.
- Load without dependence: EXMemRead=1, EXRegRt=4, IDRegRs=1, IDRegRt=2 -> no stall. Separately, register-0 match (all zero, EXMemRead=1) -> stall.
- Randomised sweep: 20 or more random 4-bit addresses with random EXMemRead, settle 10 time units -> each output equals the reference equation, and the inverted expectation always fails.
- Reset and saturation: with CNT_W=4, hold hazard for 20 edges -> StallCount=15. Then assert rst_n=0 mid-stall -> StallCount=0, Stalled=0, PCWrite=0, HazMuxCon=1 immediately.

Source files
------------

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use hazard detection with stall bookkeeping
//
// Detects a load in EX whose destination feeds a source of the instruction
// in ID. On a hazard it freezes the PC and IF/ID and injects a bubble into
// ID/EX. It also keeps a registered last-cycle-stalled flag and a saturating
// stall-cycle counter.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   IDRegRs    - Rs field of the ID-stage instruction
//   IDRegRt    - Rt field of the ID-stage instruction
//   EXRegRt    - Rt (load destination) of the EX-stage instruction
//   EXMemRead  - EX-stage instruction is a load
//   PCWrite    - 1 lets the PC update, 0 holds it
//   IFIDWrite  - 1 lets IF/ID update, 0 holds it
//   HazMuxCon  - 1 zeroes the control signals into ID/EX (bubble)
//   Stalled    - registered, previous cycle was a stall cycle
//   StallCount - registered saturating count of stall cycles

module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] IDRegRs,
    input  logic [REG_ADDR_W-1:0] IDRegRt,
    input  logic [REG_ADDR_W-1:0] EXRegRt,
    input  logic                  EXMemRead,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  HazMuxCon,
    output logic                  Stalled,
    output logic [CNT_W-1:0]      StallCount
);

    logic hazard;
    logic countFull;

    // Plain 4-state evaluation: an unknown EXMemRead propagates to the
    // outputs instead of being silently treated as "no load".
    // Register 0 is not special-cased; a match on it stalls conservatively.
    assign hazard = EXMemRead & ((EXRegRt == IDRegRs) | (EXRegRt == IDRegRt));

    // While reset is held the pipeline is frozen with a bubble selected;
    // after release the outputs follow the hazard term with no clock delay.
    assign PCWrite   = rst_n ? ~hazard : 1'b0;
    assign IFIDWrite = rst_n ? ~hazard : 1'b0;
    assign HazMuxCon = rst_n ?  hazard : 1'b1;

    assign countFull = &StallCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Stalled    <= 1'b0;
            StallCount <= '0;
        end else begin
            Stalled <= hazard;
            // A double Rs/Rt match is still one stall cycle: one count per edge.
            if (hazard && !countFull) begin
                StallCount <= StallCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit

module tb_hazard_unit;

    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] IDRegRs = '0;
    logic [AW-1:0] IDRegRt = '0;
    logic [AW-1:0] EXRegRt = '0;
    logic          EXMemRead = 1'b0;
    logic          PCWrite;
    logic          IFIDWrite;
    logic          HazMuxCon;
    logic          Stalled;
    logic [CW-1:0] StallCount;

    hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .IDRegRs(IDRegRs),
        .IDRegRt(IDRegRt),
        .EXRegRt(EXRegRt),
        .EXMemRead(EXMemRead),
        .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite),
        .HazMuxCon(HazMuxCon),
        .Stalled(Stalled),
        .StallCount(StallCount)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       pcw;
        logic       mux;
        logic       stl;
        logic [3:0] cnt;
        bit         inv;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference state: number of clock edges taken with a hazard since the
    // last reset, and whether the most recent edge was a hazard edge.
    int   hazEdges = 0;
    bit   lastHaz  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares once the combinational outputs have settled.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            check("PCWrite",    {15'b0, PCWrite},    {15'b0, e.pcw});
            check("IFIDWrite",  {15'b0, IFIDWrite},  {15'b0, e.pcw});
            check("HazMuxCon",  {15'b0, HazMuxCon},  {15'b0, e.mux});
            check("Stalled",    {15'b0, Stalled},    {15'b0, e.stl});
            check("StallCount", {12'b0, StallCount}, {12'b0, e.cnt});
            if (e.inv) begin
                checks++;
                if (PCWrite === ~e.pcw) begin
                    fails++;
                    $display("FAIL inverted_pcw: got %0b equal to inverted %0b", PCWrite, ~e.pcw);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] ex, input logic mr, input bit inv);
        exp_t e;
        bit   hz;
        @(posedge clk);
        #1;
        rst_n = r; IDRegRs = rs; IDRegRt = rt; EXRegRt = ex; EXMemRead = mr;
        hz = mr && (ex == rs || ex == rt);
        if (!r) begin
            hazEdges = 0;
            lastHaz  = 0;
        end
        e.pcw = r ? !hz : 1'b0;
        e.mux = r ?  hz : 1'b1;
        e.stl = lastHaz;
        e.cnt = 4'((hazEdges > CMAX) ? CMAX : hazEdges);
        e.inv = inv;
        expQ.push_back(e);
        if (r) begin
            if (hz) hazEdges++;
            lastHaz = hz;
        end
    endtask

    initial begin
        // reset state with hazard-looking inputs: held stalled, counters zero
        drive(0, 5, 9, 5, 1, 0);
        drive(0, 0, 0, 1, 0, 0);
        // Rs hazard, then next cycle shows Stalled and count 1
        drive(1, 5, 9, 5, 1, 0);
        // Rt hazard and double match
        drive(1, 9, 3, 3, 1, 0);
        drive(1, 3, 3, 3, 1, 0);
        // no load with all addresses equal
        drive(1, 7, 7, 7, 0, 0);
        drive(1, 7, 7, 7, 0, 0);
        // load without dependence
        drive(1, 1, 2, 4, 1, 0);
        // register 0 match stalls
        drive(1, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0);
        // random sweep over 4-bit addresses
        for (int i = 0; i < 40; i++) begin
            drive(1, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                  AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1);
        end
        // saturation: persistent hazard for 20 edges
        for (int i = 0; i < 20; i++) begin
            drive(1, 6, 2, 6, 1, 0);
        end
        drive(1, 6, 2, 6, 1, 0);
        // reset mid-stall
        drive(0, 6, 2, 6, 1, 0);
        // release: outputs evaluate immediately, registers restart from zero
        drive(1, 6, 2, 6, 1, 0);
        drive(1, 1, 2, 3, 1, 0);
        drive(1, 1, 2, 3, 1, 0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
